in512_out1536: RTL and testbench
================================

IN512_OUT1536 -- requirements
Module: in512_out1536

Interface
REQ-001 The module SHALL have parameter S_W, default 512, meaning input beat width in bits.
REQ-002 The module SHALL have parameter RATIO, default 3, meaning input beats per output beat; output width = S_W*RATIO = 1536.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  input  512  input beat payload.
REQ-006 s_axis_tvalid  input  1  input beat valid.
REQ-007 s_axis_tready  output  1  input beat accepted when high with s_axis_tvalid.
REQ-008 s_axis_tlast  input  1  last beat of a transfer.
REQ-009 weight_switch  input  1  per-beat flag, sampled with each accepted input beat.
REQ-010 m_axis_tdata  output  1536  packed output word.
REQ-011 m_axis_tvalid  output  1  output word valid.
REQ-012 m_axis_tready  input  1  downstream accepts output word.
REQ-013 m_axis_tlast  output  1  output word contains the transfer's last input beat.
REQ-014 weight_switch_out  output  1  OR of weight_switch over the input beats packed into the current output word.
REQ-015 m_axis_tkeep  output  3  per-lane valid, bit i covers tdata[512*i+511:512*i].

Function
REQ-016 Input acceptance: s_axis_tready SHALL equal (~m_axis_tvalid | m_axis_tready), combinational.
REQ-017 Beat counter cnt (2 bits, 0..2) SHALL hold the number of beats in the accumulator; accepted beat stored at lane cnt.
REQ-018 Packing order: first accepted beat of a group in lane 0 (tdata[511:0]), second in lane 1, third in lane 2 (tdata[1535:1024]).
REQ-019 A group SHALL complete on an accepted beat with cnt==2 or s_axis_tlast==1, whichever first.
REQ-020 On completion the output register SHALL load in the same edge: accumulated lanes plus current beat, unfilled lanes zero; m_axis_tvalid=1 next cycle (latency 1 cycle from completing input beat).
REQ-021 m_axis_tkeep SHALL be 3'b001/3'b011/3'b111 for groups of 1/2/3 beats; m_axis_tlast = tlast of completing beat.
REQ-022 On completion cnt SHALL return to 0 and weight_switch accumulation SHALL clear.
REQ-023 m_axis_tvalid SHALL stay high with tdata/tkeep/tlast/weight_switch_out stable until m_axis_tready; cleared on handshake unless a new group completes the same edge, then reloaded (back-to-back, no bubble).
REQ-024 Non-completing beats (cnt<2, tlast=0) SHALL also be gated by s_axis_tready (output register stall blocks all input).
REQ-025 s_axis_tvalid low SHALL not change cnt or accumulator.
REQ-026 Sustained throughput: one input beat per cycle with m_axis_tready held high.

Reset
REQ-027 rst_n low SHALL asynchronously clear cnt, accumulator, m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, weight_switch_out=0.
REQ-028 Reset mid-group or with output pending SHALL discard all partial/pending data; first beat after reset goes to lane 0.
REQ-029 s_axis_tready SHALL be 1 during and after reset (output empty).

Structure
REQ-030 Shared package SHALL hold S_W=512, RATIO=3, M_W=1536 and tkeep encodings; module imports them.
REQ-031 Single module, no sub-module; accumulator (1024 bits) and output register are separate stages.

Verification
REQ-032 6 beats A0..A5, tlast on A5, tready=1 -> two words {A2,A1,A0},{A5,A4,A3}, tkeep 111/111, tlast 0/1, each 1 cycle after A2/A5.
REQ-033 4 beats B0..B3, tlast on B3 -> {B2,B1,B0} tkeep=111 tlast=0, then {0,0,B3} tkeep=001 tlast=1.
REQ-034 m_axis_tready=0 for 5 cycles after first word valid -> tvalid and data held stable, s_axis_tready=0, no input beat lost; resume yields correct next word.
REQ-035 weight_switch=1 only on beat 1 of a 3-beat group -> weight_switch_out=1 for that word, 0 for next all-zero group.
REQ-036 rst_n pulsed low after 2 beats of a group -> outputs 0 immediately; next 3 beats form clean word, tkeep=111.
REQ-037 Random tvalid/tready (50%) over 3000 beats, random tlast -> scoreboard matches packing, tkeep, tlast exactly.

Source files
------------

// File: rtl/in512_out1536_pkg.sv
// Shared widths and keep encodings for the 512-bit to 1536-bit beat packer.
package in512_out1536_pkg;

  localparam int S_W   = 512;
  localparam int RATIO = 3;
  localparam int M_W   = S_W * RATIO;

  localparam logic [RATIO-1:0] KEEP_1 = 3'b001;
  localparam logic [RATIO-1:0] KEEP_2 = 3'b011;
  localparam logic [RATIO-1:0] KEEP_3 = 3'b111;

  // Lane-valid mask for a group holding 'beats' input beats, lowest lanes first.
  function automatic logic [RATIO-1:0] keep_mask(input int unsigned beats);
    logic [RATIO-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      m[i] = (i < beats);
    end
    return m;
  endfunction

endpackage

// File: rtl/in512_out1536.sv
// Packs up to RATIO narrow input beats into one wide output word; a group closes
// when full or on tlast. Accumulator and output register are separate stages.
module in512_out1536 #(
  parameter int S_W   = in512_out1536_pkg::S_W,
  parameter int RATIO = in512_out1536_pkg::RATIO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [S_W-1:0]       s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 weight_switch,
  output logic [S_W*RATIO-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 weight_switch_out,
  output logic [RATIO-1:0]     m_axis_tkeep
);
  import in512_out1536_pkg::*;

  localparam int OUT_W = S_W * RATIO;
  localparam int ACC_W = S_W * (RATIO - 1);
  localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             ws_acc;
  logic             s_ready;
  logic             accept;
  logic             complete;
  logic [OUT_W-1:0] acc_ext;
  logic [OUT_W-1:0] word_next;

  assign s_ready       = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = s_ready;
  assign accept        = s_axis_tvalid & s_ready;
  assign complete      = accept & ((cnt == LAST_CNT) | s_axis_tlast);
  assign acc_ext       = {{S_W{1'b0}}, acc};

  // Lanes below cnt come from the accumulator, lane cnt is the live beat, the rest stay zero.
  always_comb begin
    word_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) < cnt) begin
        word_next[i*S_W +: S_W] = acc_ext[i*S_W +: S_W];
      end else if (CNT_W'(i) == cnt) begin
        word_next[i*S_W +: S_W] = s_axis_tdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      ws_acc <= 1'b0;
    end else if (accept) begin
      if (complete) begin
        cnt    <= '0;
        ws_acc <= 1'b0;
      end else begin
        for (int i = 0; i < RATIO - 1; i++) begin
          if (CNT_W'(i) == cnt) acc[i*S_W +: S_W] <= s_axis_tdata;
        end
        cnt    <= cnt + CNT_W'(1);
        ws_acc <= ws_acc | weight_switch;
      end
    end
  end

  // A completing beat reloads the output even while the previous word is being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tkeep      <= '0;
      weight_switch_out <= 1'b0;
    end else if (complete) begin
      m_axis_tdata      <= word_next;
      m_axis_tvalid     <= 1'b1;
      m_axis_tlast      <= s_axis_tlast;
      m_axis_tkeep      <= keep_mask(int'(cnt) + 1);
      weight_switch_out <= ws_acc | weight_switch;
    end else if (m_axis_tready) begin
      m_axis_tvalid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_in512_out1536.sv
// Bench for in512_out1536: directed vector table, stall/reset sequences, randomized scoreboard.
module tb_in512_out1536;
  import in512_out1536_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [511:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          weight_switch;
  logic [1535:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          weight_switch_out;
  logic [2:0]    m_axis_tkeep;

  always #5 clk = ~clk;

  in512_out1536 dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .weight_switch(weight_switch),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .weight_switch_out(weight_switch_out), .m_axis_tkeep(m_axis_tkeep)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [1535:0] act, input logic [1535:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (low 128 bits shown)", nm, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [511:0] rnd_beat();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Reference model: beats are collected in arrival order and flushed as a word
  // when three are held or a beat carries tlast.
  typedef struct {
    logic [1535:0] data;
    logic [2:0]    keep;
    logic          last;
    logic          ws;
  } word_t;

  word_t        exp_q[$];
  logic [511:0] part[$];
  logic         part_ws = 1'b0;

  task automatic model_beat(input logic [511:0] d, input logic ws, input logic last);
    word_t w;
    part.push_back(d);
    part_ws = part_ws | ws;
    if (last || part.size() == 3) begin
      w.data = '0;
      foreach (part[i]) w.data[i*512 +: 512] = part[i];
      w.keep = 3'((1 << part.size()) - 1);
      w.last = last;
      w.ws   = part_ws;
      exp_q.push_back(w);
      part.delete();
      part_ws = 1'b0;
    end
  endtask

  typedef struct {
    logic [511:0]  d;
    logic          ws;
    logic          last;
    logic          exp_v;
    logic [1535:0] exp_d;
    logic [2:0]    exp_k;
    logic          exp_l;
    logic          exp_ws;
  } vec_t;

  vec_t         vt[16];
  logic [511:0] a[16];
  logic [511:0] d[6];
  logic [511:0] e[5];
  logic [1535:0] w1;

  task automatic drive_beat(input logic [511:0] dat, input logic ws, input logic last);
    s_axis_tdata  = dat;
    s_axis_tvalid = 1'b1;
    weight_switch = ws;
    s_axis_tlast  = last;
    @(posedge clk); #1;
  endtask

  initial begin
    int beats;
    int cyc;
    logic accepted;
    logic hs;
    word_t w;

    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    weight_switch = 1'b0; m_axis_tready = 1'b1;
    #1;
    chk("reset_tvalid", 1536'(m_axis_tvalid), 1536'(0));
    chk("reset_tdata", m_axis_tdata, '0);
    chk("reset_tkeep", 1536'(m_axis_tkeep), 1536'(0));
    chk("reset_tready", 1536'(s_axis_tready), 1536'(1));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table: groups A (6 beats), B (3+1), C (ws on second beat).
    for (int i = 0; i < 16; i++) begin
      a[i] = rnd_beat();
      vt[i] = '{d: a[i], ws: 1'b0, last: 1'b0, exp_v: 1'b0, exp_d: '0, exp_k: 3'b000, exp_l: 1'b0, exp_ws: 1'b0};
    end
    vt[5].last = 1'b1; vt[9].last = 1'b1; vt[15].last = 1'b1; vt[11].ws = 1'b1;
    vt[2].exp_v = 1'b1;  vt[2].exp_d = {a[2], a[1], a[0]};     vt[2].exp_k = KEEP_3;
    vt[5].exp_v = 1'b1;  vt[5].exp_d = {a[5], a[4], a[3]};     vt[5].exp_k = KEEP_3;  vt[5].exp_l = 1'b1;
    vt[8].exp_v = 1'b1;  vt[8].exp_d = {a[8], a[7], a[6]};     vt[8].exp_k = KEEP_3;
    vt[9].exp_v = 1'b1;  vt[9].exp_d = {1024'b0, a[9]};        vt[9].exp_k = KEEP_1;  vt[9].exp_l = 1'b1;
    vt[12].exp_v = 1'b1; vt[12].exp_d = {a[12], a[11], a[10]}; vt[12].exp_k = KEEP_3; vt[12].exp_ws = 1'b1;
    vt[15].exp_v = 1'b1; vt[15].exp_d = {a[15], a[14], a[13]}; vt[15].exp_k = KEEP_3; vt[15].exp_l = 1'b1;

    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_axis_tdata = vt[i].d; s_axis_tvalid = 1'b1;
      weight_switch = vt[i].ws; s_axis_tlast = vt[i].last;
      #1;
      chk($sformatf("vec%0d_s_tready", i), 1536'(s_axis_tready), 1536'(1));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_tvalid", i), 1536'(m_axis_tvalid), 1536'(vt[i].exp_v));
      if (vt[i].exp_v) begin
        chk($sformatf("vec%0d_tdata", i), m_axis_tdata, vt[i].exp_d);
        chk($sformatf("vec%0d_tkeep", i), 1536'(m_axis_tkeep), 1536'(vt[i].exp_k));
        chk($sformatf("vec%0d_tlast", i), 1536'(m_axis_tlast), 1536'(vt[i].exp_l));
        chk($sformatf("vec%0d_ws_out", i), 1536'(weight_switch_out), 1536'(vt[i].exp_ws));
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; weight_switch = 1'b0;
    @(posedge clk); #1;

    // Output stall: five cycles of m_axis_tready low with a beat waiting.
    for (int i = 0; i < 6; i++) d[i] = rnd_beat();
    w1 = {d[2], d[1], d[0]};
    for (int i = 0; i < 3; i++) drive_beat(d[i], 1'b0, 1'b0);
    chk("stall_first_valid", 1536'(m_axis_tvalid), 1536'(1));
    chk("stall_first_data", m_axis_tdata, w1);
    m_axis_tready = 1'b0;
    s_axis_tdata = d[3];
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d_s_tready", k), 1536'(s_axis_tready), 1536'(0));
      @(posedge clk); #1;
      chk($sformatf("stall%0d_tvalid", k), 1536'(m_axis_tvalid), 1536'(1));
      chk($sformatf("stall%0d_tdata", k), m_axis_tdata, w1);
      chk($sformatf("stall%0d_tkeep", k), 1536'(m_axis_tkeep), 1536'(KEEP_3));
    end
    m_axis_tready = 1'b1;
    #1;
    chk("resume_s_tready", 1536'(s_axis_tready), 1536'(1));
    @(posedge clk); #1;
    chk("resume_tvalid_cleared", 1536'(m_axis_tvalid), 1536'(0));
    drive_beat(d[4], 1'b0, 1'b0);
    chk("resume_mid_tvalid", 1536'(m_axis_tvalid), 1536'(0));
    drive_beat(d[5], 1'b0, 1'b1);
    chk("resume_word_valid", 1536'(m_axis_tvalid), 1536'(1));
    chk("resume_word_data", m_axis_tdata, {d[5], d[4], d[3]});
    chk("resume_word_tkeep", 1536'(m_axis_tkeep), 1536'(KEEP_3));
    chk("resume_word_tlast", 1536'(m_axis_tlast), 1536'(1));
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a group: partial beats and stale output are discarded.
    for (int i = 0; i < 5; i++) e[i] = rnd_beat();
    drive_beat(e[0], 1'b1, 1'b0);
    drive_beat(e[1], 1'b0, 1'b0);
    s_axis_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tvalid", 1536'(m_axis_tvalid), 1536'(0));
    chk("rst_tlast", 1536'(m_axis_tlast), 1536'(0));
    chk("rst_tkeep", 1536'(m_axis_tkeep), 1536'(0));
    chk("rst_ws_out", 1536'(weight_switch_out), 1536'(0));
    chk("rst_s_tready", 1536'(s_axis_tready), 1536'(1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(e[2], 1'b0, 1'b0);
    drive_beat(e[3], 1'b0, 1'b0);
    drive_beat(e[4], 1'b0, 1'b0);
    chk("post_rst_valid", 1536'(m_axis_tvalid), 1536'(1));
    chk("post_rst_data", m_axis_tdata, {e[4], e[3], e[2]});
    chk("post_rst_tkeep", 1536'(m_axis_tkeep), 1536'(KEEP_3));
    chk("post_rst_ws_out", 1536'(weight_switch_out), 1536'(0));
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    beats = 0;
    cyc = 0;
    accepted = 1'b0;
    while (beats < 3000 && cyc < 40000) begin
      if (!s_axis_tvalid || accepted) begin
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tdata  = rnd_beat();
        s_axis_tlast  = ($urandom_range(0, 3) == 0);
        weight_switch = ($urandom_range(0, 7) == 0);
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      accepted = s_axis_tvalid && s_axis_tready;
      hs = m_axis_tvalid && m_axis_tready;
      if (s_axis_tready !== (~m_axis_tvalid | m_axis_tready)) begin
        chk("rand_s_tready", 1536'(s_axis_tready), 1536'(~m_axis_tvalid | m_axis_tready));
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_word", 1536'(m_axis_tvalid), 1536'(0));
        end else begin
          w = exp_q.pop_front();
          chk("rand_tdata", m_axis_tdata, w.data);
          chk("rand_tkeep", 1536'(m_axis_tkeep), 1536'(w.keep));
          chk("rand_tlast", 1536'(m_axis_tlast), 1536'(w.last));
          chk("rand_ws_out", 1536'(weight_switch_out), 1536'(w.ws));
        end
      end
      if (accepted) begin
        model_beat(s_axis_tdata, weight_switch, s_axis_tlast);
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_beat_budget", 1536'(beats), 1536'(3000));

    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected_word", 1536'(m_axis_tvalid), 1536'(0));
        end else begin
          w = exp_q.pop_front();
          chk("drain_tdata", m_axis_tdata, w.data);
          chk("drain_tkeep", 1536'(m_axis_tkeep), 1536'(w.keep));
          chk("drain_tlast", 1536'(m_axis_tlast), 1536'(w.last));
        end
      end
      @(posedge clk); #1;
    end
    chk("scoreboard_empty", 1536'(exp_q.size()), 1536'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
